// File: rtl/ddr_ui_pkg.sv
// Shared types for the SDRAM user-interface command arbiter: command codes,
// arbiter FSM states and the channel-id width helper.
package ddr_ui_pkg;

    localparam int unsigned DDR_CMD_W = 3;

    typedef enum logic [DDR_CMD_W-1:0] {
        NOP       = 3'b000,
        READ      = 3'b001,
        WRITE     = 3'b010,
        REFRESH   = 3'b011,
        PRECHARGE = 3'b100,
        LOAD_MODE = 3'b101,
        LOAD_REG1 = 3'b110,
        LOAD_REG2 = 3'b111
    } cmd_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } arb_state_t;

    // A single-channel build still carries a 1-bit channel id.
    function automatic int unsigned chid_width(input int unsigned num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/ddr_ui_cmd_fifo.sv
// Single-clock per-channel command FIFO; full/empty are registered and a push
// is judged against the full flag from before any same-edge pop.
module ddr_ui_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       head_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_d;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CNT_W'(1);
            2'b01:   count_d = count - CNT_W'(1);
            default: count_d = count;
        endcase
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule

// File: rtl/ddr_ui_cmd_arbiter.sv
// Multi-channel SDRAM user-interface front end: per-channel FIFOs, round-robin
// (or, with DDR_UI_FIXED_PRIO_EN defined, fixed lowest-index) command issue.
module ddr_ui_cmd_arbiter
    import ddr_ui_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_W       = DATA_W / 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic [NUM_CH*DDR_CMD_W-1:0]     CH_CMD,
    input  logic [NUM_CH*ADDR_W-1:0]        CH_ADDR,
    input  logic [NUM_CH*DATA_W-1:0]        CH_DATAIN,
    input  logic [NUM_CH*DM_W-1:0]          CH_DM,
    output logic [NUM_CH-1:0]               CH_CMDACK,
    output logic [NUM_CH-1:0]               CH_FULL,
    output logic [DDR_CMD_W-1:0]            MC_CMD,
    output logic [ADDR_W-1:0]               MC_ADDR,
    output logic [DATA_W-1:0]               MC_DATAIN,
    output logic [DM_W-1:0]                 MC_DM,
    output logic [chid_width(NUM_CH)-1:0]   MC_CHID,
    input  logic                            MC_CMDACK
);

    localparam int unsigned CHID_W = chid_width(NUM_CH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        cmd_t              cmd;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DM_W-1:0]   dm;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] empty;
    entry_t            head [NUM_CH];

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic              pop_en_c;
    logic              found_c;
    logic [CHID_W-1:0] grant_c;
    entry_t            sel_c;
`ifndef DDR_UI_FIXED_PRIO_EN
    logic [CHID_W-1:0] last_grant_q;
    logic [CHID_W-1:0] cand_c;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DDR_CMD_W-1:0] cmd_i;
        entry_t               wdata_i;
        logic [ENTRY_W-1:0]   head_i;
        logic [CNT_W-1:0]     count_i;

        assign cmd_i   = CH_CMD[i*DDR_CMD_W +: DDR_CMD_W];
        assign wdata_i = {cmd_i, CH_ADDR[i*ADDR_W +: ADDR_W],
                          CH_DATAIN[i*DATA_W +: DATA_W], CH_DM[i*DM_W +: DM_W]};
        // The ack cycle blocks a re-push of a CMD the user is still holding.
        assign push[i] = (cmd_i != DDR_CMD_W'(NOP)) && !CH_FULL[i] && !CH_CMDACK[i];
        assign pop[i]  = pop_en_c && (grant_c == CHID_W'(i));
        assign head[i] = entry_t'(head_i);

        ddr_ui_cmd_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk    (CLK),
            .rst_n  (RESET_N),
            .push   (push[i]),
            .pop    (pop[i]),
            .wdata  (wdata_i),
            .head_c (head_i),
            .full   (CH_FULL[i]),
            .empty  (empty[i]),
            .count  (count_i)
        );

        a_full_matches_count : assert property (@(posedge CLK) disable iff (!RESET_N)
            CH_FULL[i] == (count_i == CNT_W'(FIFO_DEPTH)));
    end

    // Grant selection and FSM next state.
    always_comb begin
        state_d  = state_q;
        pop_en_c = 1'b0;
        found_c  = 1'b0;
        grant_c  = '0;
`ifdef DDR_UI_FIXED_PRIO_EN
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found_c && !empty[k]) begin
                grant_c = CHID_W'(k);
                found_c = 1'b1;
            end
        end
`else
        cand_c = last_grant_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_c = (cand_c == CHID_W'(NUM_CH - 1)) ? '0 : cand_c + CHID_W'(1);
            if (!found_c && !empty[cand_c]) begin
                grant_c = cand_c;
                found_c = 1'b1;
            end
        end
`endif
        sel_c = head[grant_c];
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    pop_en_c = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (MC_CMDACK) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            CH_CMDACK    <= '0;
            MC_CMD       <= '0;
            MC_ADDR      <= '0;
            MC_DATAIN    <= '0;
            MC_DM        <= '0;
            MC_CHID      <= '0;
`ifndef DDR_UI_FIXED_PRIO_EN
            last_grant_q <= CHID_W'(NUM_CH - 1);
`endif
        end else begin
            state_q   <= state_d;
            CH_CMDACK <= push;
            if (pop_en_c) begin
                MC_CMD       <= sel_c.cmd;
                MC_ADDR      <= sel_c.addr;
                MC_DATAIN    <= sel_c.data;
                MC_DM        <= sel_c.dm;
                MC_CHID      <= grant_c;
`ifndef DDR_UI_FIXED_PRIO_EN
                last_grant_q <= grant_c;
`endif
            end else if ((state_q == ISSUE) && MC_CMDACK) begin
                MC_CMD <= '0;
            end
        end
    end

endmodule
